truth_table_lut_seq: RTL
========================

// Module: truth_table_lut_seq
// PURPOSE
//  Parametrised, reprogrammable N-input truth-table gate for netlist benchmarks.
//  Replaces fixed per-function gate modules: the table is loaded serially at run time,
//  queries use valid/ready, and a sweep mode emits every input combination in order.
//  Sits between the stimulus driver and the response checker in the gate benchmark harness.
// PARAMETERS
//  N_IN      3       number of inputs, legal range 1..6; table width TT_W = 2**N_IN
//  RESET_TT  64'h0   table value after reset; only the low TT_W bits are used
// PORTS
//  clk          in   1       the single clock
//  rst          in   1       synchronous, active-high reset
//  ld_start     in   1       pulse: begin a new serial table load
//  ld_valid     in   1       ld_bit is valid this cycle
//  ld_bit       in   1       table bit; sent LSB first (index 0 first)
//  ld_ready     out  1       load bit accepted when ld_valid && ld_ready
//  load_done    out  1       1-cycle pulse when a new table is committed
//  sweep_start  in   1       pulse: emit outputs for all 2**N_IN input combinations
//  in_valid     in   1       query valid
//  in_data      in   N_IN    input combination; in_data[N_IN-1] is input 1 (the MSB)
//  in_ready     out  1       query accepted when in_valid && in_ready
//  out_valid    out  1       result valid
//  out_data     out  1       tt_q[idx]
//  out_idx      out  N_IN    input combination that produced out_data
//  out_last     out  1       high on the final sweep result; 0 for ordinary queries
//  out_ready    in   1       result consumed when out_valid && out_ready
//  busy         out  1       state != IDLE
//  tt_q         out  TT_W    committed table
// BEHAVIOUR
//  Reset: state=IDLE; tt_q=RESET_TT[TT_W-1:0]; every other output, the shadow table and
//   the counter are 0. A reset in any state aborts the load or sweep in progress,
//   discards the shadow table and drops any pending result.
//  FSM states: IDLE, LOAD, SWEEP.
//  Priority in IDLE when requests coincide: ld_start > sweep_start > in_valid.
//   - A losing in_valid is not accepted (in_ready=0 that cycle).
//   - ld_start and sweep_start are ignored outside IDLE, except ld_start in LOAD (restart).
//  IDLE -> LOAD on ld_start.
//   - Counter cnt (N_IN+1 bits) = 0; ld_ready=1 only in LOAD.
//   - Each accepted bit is written to shadow[cnt], then cnt increments.
//   - When the bit at cnt = TT_W-1 is accepted: tt_q <= shadow including that bit,
//     committed atomically on the next edge; load_done pulses 1 cycle; return to IDLE.
//   - ld_start in LOAD restarts the load: cnt=0; the old shadow is discarded.
//   - tt_q is unchanged until commit.
//  IDLE -> SWEEP on sweep_start: cnt=0.
//   - Each cycle the output slot is free, push result {idx=cnt, data=tt_q[cnt]}.
//   - out_last=1 when cnt = TT_W-1; after that push, return to IDLE.
//   - Stalls losslessly while out_ready=0; ld_start is ignored until IDLE.
//  Query path (IDLE only): in_ready = (state==IDLE) && (!out_valid || out_ready) && no
//   higher-priority request. Latency is 1 cycle from acceptance to out_valid.
//   - Back-to-back throughput is 1 per cycle when out_ready=1.
//  Output slot is 1 entry: out_* are held stable while out_valid && !out_ready.
//   - A result pending when LOAD starts keeps its old-table value.
//  Index width: cnt compares against TT_W using N_IN+1 bits, so N_IN=6 (64) never aliases 0.
// STRUCTURE
//  Package truth_table_pkg:
//   - typedef enum {IDLE, LOAD, SWEEP} tt_state_e
//   - localparam MAX_N_IN=6
//   - typedef struct {idx, data, last} tt_result_t
//  Sub-module tt_out_stage: 1-entry valid/ready result register with a combinational
//   free signal. The FSM, shadow register, counter and table stay in this module.
// TESTING
//  1. Reset with N_IN=3, RESET_TT=0 -> tt_q=8'h00, all outputs 0; a query returns out_data=0.
//  2. Load bits 0,0,1,1,0,1,1,1 (LSB first) -> load_done once, tt_q=8'hEC;
//     queries 3'b010->1, 3'b100->0, 3'b101->1, each one cycle after acceptance.
//  3. Sweep with out_ready toggling 1/0 -> 8 results, idx 0..7 in order,
//     data=0,0,1,1,0,1,1,1, out_last only at idx 7, no drops or duplicates.
//  4. ld_start after 5 bits, then a full 8-bit load of 8'h01 -> tt_q=8'h01,
//     one load_done; tt_q=8'hEC is unchanged until the commit.
//  5. ld_start, sweep_start and in_valid in the same IDLE cycle -> LOAD entered,
//     query not accepted, no sweep; rst asserted mid-SWEEP -> out_valid=0 next cycle,
//     tt_q=RESET_TT.
//  6. N_IN=6: load 64 bits with only bit 63 set -> query 6'h3F=1, 6'h00=0;
//     a sweep emits exactly 64 results.

Source files
------------

// File: rtl/truth_table_pkg.sv
// Shared types for the reprogrammable truth-table gate: FSM state and result-slot payload.
package truth_table_pkg;

    localparam int MAX_N_IN = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SWEEP = 2'd2
    } tt_state_e;

    // idx is sized for the widest table; narrower instances zero-extend
    typedef struct packed {
        logic [MAX_N_IN-1:0] idx;
        logic                data;
        logic                last;
    } tt_result_t;

endpackage

// File: rtl/tt_out_stage.sv
// Purpose: 1-entry valid/ready result register feeding the response checker.
// Latency: 1 cycle from push to out_valid.
// Backpressure: contents held while out_valid && !out_ready; free tells the producer when a push lands.
module tt_out_stage
    import truth_table_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  tt_result_t push_dat,
    output logic       free,
    output logic       out_valid,
    input  logic       out_ready,
    output tt_result_t out_res
);

    assign free = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_res   <= '0;
        end else if (free) begin
            out_valid <= push;
            if (push) begin
                out_res <= push_dat;
            end
        end
    end

endmodule

// File: rtl/truth_table_lut_seq.sv
// Purpose: run-time loadable N-input truth table with serial load, single queries and full sweep.
// Latency: query result 1 cycle after acceptance; new table visible the cycle load_done pulses.
// Backpressure: queries and sweep steps wait on the 1-entry output slot; load bits accepted every LOAD cycle.
module truth_table_lut_seq
    import truth_table_pkg::*;
#(
    parameter int          N_IN     = 3,
    parameter logic [63:0] RESET_TT = 64'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ld_start,
    input  logic                   ld_valid,
    input  logic                   ld_bit,
    output logic                   ld_ready,
    output logic                   load_done,
    input  logic                   sweep_start,
    input  logic                   in_valid,
    input  logic [N_IN-1:0]        in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic                   out_data,
    output logic [N_IN-1:0]        out_idx,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic                   busy,
    output logic [(2**N_IN)-1:0]   tt_q
);

    localparam int              TT_W     = 2**N_IN;
    localparam logic [N_IN:0]   LAST_IDX = (N_IN+1)'(TT_W-1);

    tt_state_e         state_q, state_d;
    logic [N_IN:0]     cnt_q, cnt_d;
    logic [TT_W-1:0]   shadow_q, shadow_d;
    logic [TT_W-1:0]   tt_d;
    logic              load_done_d;
    logic              push;
    tt_result_t        push_res;
    tt_result_t        out_res;
    logic              free;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shadow_q  <= '0;
            tt_q      <= RESET_TT[TT_W-1:0];
            load_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            tt_q      <= tt_d;
            load_done <= load_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        tt_d        = tt_q;
        load_done_d = 1'b0;
        push        = 1'b0;
        push_res    = '0;
        in_ready    = 1'b0;
        ld_ready    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_start) begin
                    state_d  = LOAD;
                    cnt_d    = '0;
                    shadow_d = '0;
                end else if (sweep_start) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end else begin
                    in_ready = free && !rst;
                    if (in_valid && free) begin
                        push          = 1'b1;
                        push_res.idx  = MAX_N_IN'(in_data);
                        push_res.data = tt_q[in_data];
                    end
                end
            end
            LOAD: begin
                // a restart outranks a coincident bit, so that bit is not handshaken
                ld_ready = !ld_start;
                if (ld_start) begin
                    cnt_d    = '0;
                    shadow_d = '0;
                end else if (ld_valid) begin
                    shadow_d[cnt_q[N_IN-1:0]] = ld_bit;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        tt_d        = shadow_d;
                        load_done_d = 1'b1;
                        state_d     = IDLE;
                        cnt_d       = '0;
                    end
                end
            end
            SWEEP: begin
                if (free) begin
                    push          = 1'b1;
                    push_res.idx  = MAX_N_IN'(cnt_q[N_IN-1:0]);
                    push_res.data = tt_q[cnt_q[N_IN-1:0]];
                    push_res.last = (cnt_q == LAST_IDX);
                    cnt_d         = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    tt_out_stage u_out_stage (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_dat  (push_res),
        .free      (free),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res)
    );

    assign out_data = out_res.data;
    assign out_idx  = out_res.idx[N_IN-1:0];
    assign out_last = out_res.last;
    assign busy     = (state_q != IDLE);

endmodule
